// File: rtl/sram_arb_pkg.sv
// Shared encodings for the SRAM request arbiter: grant-lock states and the
// requester ids stored in the in-order response FIFO.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_DATA = 2'd1,
        G_INST = 2'd2
    } grant_e;

    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

endpackage

// File: rtl/sram_req_arbiter_id_fifo.sv
// In-order owner-id FIFO: one 1-bit entry per accepted transaction, popped by
// each downstream response beat.
module id_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic pop_i,
    input  logic din_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] mem_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == {CW{1'b0}});
    assign head_o    = mem_q[rd_ptr_q];
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;

    // Storage, pointers (power-of-two depth wraps naturally) and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= {DEPTH{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Two-to-one SRAM port arbiter (data over inst) with grant lock until accept
// and in-order routing of response beats back to their owner.
module sram_req_arbiter
    import sram_arb_pkg::*;
#(
    parameter int OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        err_spurious
);

    grant_e state_q, state_d;
    logic   gnt_id_s;
    logic   sel_req_s;
    logic   mem_req_s;
    logic   accept_s;
    logic   fifo_full_s;
    logic   fifo_empty_s;
    logic   fifo_head_s;
    logic   pop_s;
    logic   err_q;

    // Grant selection, full-FIFO gating and lock next-state.
    always_comb begin
        state_d   = state_q;
        gnt_id_s  = ID_DATA;
        sel_req_s = 1'b0;
        case (state_q)
            G_NONE: begin
                if (data_req) begin
                    gnt_id_s  = ID_DATA;
                    sel_req_s = 1'b1;
                end else if (inst_req) begin
                    gnt_id_s  = ID_INST;
                    sel_req_s = 1'b1;
                end else begin
                    gnt_id_s  = ID_DATA;
                    sel_req_s = 1'b0;
                end
            end
            G_DATA: begin
                gnt_id_s  = ID_DATA;
                sel_req_s = data_req;
            end
            G_INST: begin
                gnt_id_s  = ID_INST;
                sel_req_s = inst_req;
            end
            default: begin
                gnt_id_s  = ID_DATA;
                sel_req_s = 1'b0;
            end
        endcase

        // A full FIFO blocks issue even when a pop lands this same cycle.
        mem_req_s = sel_req_s & ~fifo_full_s & ~reset;
        accept_s  = mem_req_s & mem_addr_ok;

        if (state_q == G_NONE) begin
            if (mem_req_s & ~mem_addr_ok) begin
                state_d = (gnt_id_s == ID_DATA) ? G_DATA : G_INST;
            end else begin
                state_d = G_NONE;
            end
        end else begin
            if (~sel_req_s | accept_s) begin
                state_d = G_NONE;
            end else begin
                state_d = state_q;
            end
        end
    end

    // Grant lock register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= G_NONE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sticky flag for response beats that have no outstanding owner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (mem_data_ok & fifo_empty_s) begin
            err_q <= 1'b1;
        end else begin
            err_q <= err_q;
        end
    end

    assign pop_s = mem_data_ok & ~fifo_empty_s & ~reset;

    id_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (accept_s),
        .pop_i   (pop_s),
        .din_i   (gnt_id_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .head_o  (fifo_head_s)
    );

    assign mem_req   = mem_req_s;
    assign mem_wr    = (gnt_id_s == ID_DATA) ? data_wr    : inst_wr;
    assign mem_size  = (gnt_id_s == ID_DATA) ? data_size  : inst_size;
    assign mem_wstrb = (gnt_id_s == ID_DATA) ? data_wstrb : inst_wstrb;
    assign mem_addr  = (gnt_id_s == ID_DATA) ? data_addr  : inst_addr;
    assign mem_wdata = (gnt_id_s == ID_DATA) ? data_wdata : inst_wdata;

    assign inst_addr_ok = accept_s & (gnt_id_s == ID_INST);
    assign data_addr_ok = accept_s & (gnt_id_s == ID_DATA);
    assign inst_data_ok = pop_s & (fifo_head_s == ID_INST);
    assign data_data_ok = pop_s & (fifo_head_s == ID_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;
    assign err_spurious = err_q;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed vector table plus randomized run against a queue-based model of
// the arbiter's grant, lock and in-order response rules.
module tb_sram_req_arbiter;

    localparam int OUT = 4;
    localparam logic [31:0] IA = 32'h0000_1000;
    localparam logic [31:0] DA = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 1'b0, inst_wr = 1'b0, data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  inst_size = 2'd0, data_size = 2'd0;
    logic [3:0]  inst_wstrb = 4'd0, data_wstrb = 4'd0;
    logic [31:0] inst_addr = IA, inst_wdata = 32'd0, data_addr = DA, data_wdata = 32'd0;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        err_spurious;

    int n_cmp = 0;
    int n_fail = 0;

    sram_req_arbiter #(.OUTSTANDING(OUT)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic ir, dr, aok, dok;
        logic [31:0] rd;
        logic mreq;
        logic [31:0] maddr;
        logic iaok, daok, idok, ddok, err;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic ir, dr, aok, dok, input logic [31:0] rd,
                                input logic mreq, input logic [31:0] maddr,
                                input logic iaok, daok, idok, ddok, err);
        vec_t v;
        v.ir = ir; v.dr = dr; v.aok = aok; v.dok = dok; v.rd = rd;
        v.mreq = mreq; v.maddr = maddr; v.iaok = iaok; v.daok = daok;
        v.idok = idok; v.ddok = ddok; v.err = err;
        vq.push_back(v);
    endfunction

    // Behavioural model state: outstanding owner queue (0 inst, 1 data),
    // current lock holder (-1 none) and sticky error.
    int  mq[$];
    int  lock_m;
    bit  err_m;

    task automatic model_cycle(input int idx);
        int owner;
        bit rq, fwd, acc, dok;
        int hd;
        owner = (lock_m >= 0) ? lock_m : (data_req ? 1 : (inst_req ? 0 : -1));
        rq    = (owner == 1) ? data_req : ((owner == 0) ? inst_req : 1'b0);
        fwd   = rq && (mq.size() < OUT);
        acc   = fwd && mem_addr_ok;
        dok   = mem_data_ok && (mq.size() > 0);
        hd    = dok ? mq[0] : 0;
        chk("r_mem_req", {31'd0, mem_req}, {31'd0, fwd});
        if (fwd) begin
            chk("r_mem_addr", mem_addr, (owner == 1) ? data_addr : inst_addr);
            chk("r_mem_wdata", mem_wdata, (owner == 1) ? data_wdata : inst_wdata);
            chk("r_mem_ctl", {25'd0, mem_wr, mem_size, mem_wstrb},
                (owner == 1) ? {25'd0, data_wr, data_size, data_wstrb}
                             : {25'd0, inst_wr, inst_size, inst_wstrb});
        end
        chk("r_inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, acc && owner == 0});
        chk("r_data_addr_ok", {31'd0, data_addr_ok}, {31'd0, acc && owner == 1});
        chk("r_inst_data_ok", {31'd0, inst_data_ok}, {31'd0, dok && hd == 0});
        chk("r_data_data_ok", {31'd0, data_data_ok}, {31'd0, dok && hd == 1});
        chk("r_rdata", inst_rdata ^ data_rdata, 32'd0);
        chk("r_inst_rdata", inst_rdata, mem_rdata);
        chk("r_err", {31'd0, err_spurious}, {31'd0, err_m});
        @(posedge clk);
        if (mem_data_ok && mq.size() == 0) err_m = 1'b1;
        if (dok) void'(mq.pop_front());
        if (acc) mq.push_back(owner);
        if (lock_m >= 0) lock_m = (rq && !acc) ? lock_m : -1;
        else             lock_m = (fwd && !acc) ? owner : -1;
        if (idx < 0) $display("unreachable");
    endtask

    initial begin
        // Directed vectors: ir dr aok dok rdata | mreq maddr iaok daok idok ddok err
        add(1,1,1,0,32'h0,  1,DA,   0,1,0,0,0);
        add(1,0,1,0,32'h0,  1,IA,   1,0,0,0,0);
        add(1,0,0,0,32'h0,  1,IA,   0,0,0,0,0);
        add(1,0,0,0,32'h0,  1,IA,   0,0,0,0,0);
        add(1,0,0,0,32'h0,  1,IA,   0,0,0,0,0);
        add(1,1,0,0,32'h0,  1,IA,   0,0,0,0,0);
        add(1,1,1,0,32'h0,  1,IA,   1,0,0,0,0);
        add(0,1,1,0,32'h0,  1,DA,   0,1,0,0,0);
        add(1,1,1,0,32'h0,  0,32'h0,0,0,0,0,0);
        add(1,1,1,1,32'h11, 0,32'h0,0,0,0,1,0);
        add(1,1,0,1,32'h22, 1,DA,   0,0,1,0,0);
        add(1,1,0,1,32'h33, 1,DA,   0,0,1,0,0);
        add(1,0,0,0,32'h0,  0,32'h0,0,0,0,0,0);
        add(1,0,0,0,32'h0,  1,IA,   0,0,0,0,0);
        add(0,0,0,1,32'h44, 0,32'h0,0,0,0,1,0);
        add(0,0,0,1,32'h55, 0,32'h0,0,0,0,0,0);
        add(0,0,0,0,32'h0,  0,32'h0,0,0,0,0,1);
        add(1,0,1,0,32'h0,  1,IA,   1,0,0,0,1);
        add(0,1,1,0,32'h0,  1,DA,   0,1,0,0,1);
        add(1,0,1,0,32'h0,  1,IA,   1,0,0,0,1);
        add(0,0,0,1,32'h11, 0,32'h0,0,0,1,0,1);
        add(0,0,0,1,32'h22, 0,32'h0,0,0,0,1,1);
        add(0,0,0,1,32'h33, 0,32'h0,0,0,1,0,1);
        add(0,0,0,0,32'h0,  0,32'h0,0,0,0,0,1);

        inst_req = 1'b1; data_req = 1'b1; mem_data_ok = 1'b1;
        #2;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_oks", {28'd0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 32'd0);
        chk("rst_err", {31'd0, err_spurious}, 32'd0);
        repeat (2) @(posedge clk);

        @(negedge clk);
        reset = 1'b0;
        foreach (vq[i]) begin
            if (i != 0) @(negedge clk);
            inst_req = vq[i].ir; data_req = vq[i].dr;
            mem_addr_ok = vq[i].aok; mem_data_ok = vq[i].dok; mem_rdata = vq[i].rd;
            #2;
            chk($sformatf("v%0d_mem_req", i), {31'd0, mem_req}, {31'd0, vq[i].mreq});
            if (vq[i].mreq) chk($sformatf("v%0d_mem_addr", i), mem_addr, vq[i].maddr);
            chk($sformatf("v%0d_addr_ok", i), {30'd0, inst_addr_ok, data_addr_ok},
                {30'd0, vq[i].iaok, vq[i].daok});
            chk($sformatf("v%0d_data_ok", i), {30'd0, inst_data_ok, data_data_ok},
                {30'd0, vq[i].idok, vq[i].ddok});
            chk($sformatf("v%0d_rdata", i), data_rdata, vq[i].rd);
            chk($sformatf("v%0d_err", i), {31'd0, err_spurious}, {31'd0, vq[i].err});
        end

        // Reset mid-operation with two transactions outstanding.
        @(negedge clk);
        inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b0;
        @(negedge clk);
        data_req = 1'b0;
        @(negedge clk);
        inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("mid_rst_oks", {28'd0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 32'd0);
        chk("mid_rst_err", {31'd0, err_spurious}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        inst_req = 1'b0; data_req = 1'b1; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        #2;
        chk("post_rst_mem_req", {31'd0, mem_req}, 32'd1);
        chk("post_rst_mem_addr", mem_addr, DA);
        chk("post_rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        @(negedge clk);
        data_req = 1'b0; mem_data_ok = 1'b0;
        #2;
        chk("post_rst_err", {31'd0, err_spurious}, 32'd1);

        // Randomized run against the model, from a fresh reset.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mq.delete();
        lock_m = -1;
        err_m = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            inst_req    = ($urandom_range(0, 99) < 55);
            data_req    = ($urandom_range(0, 99) < 45);
            inst_wr     = $urandom_range(0, 1);
            data_wr     = $urandom_range(0, 1);
            inst_size   = 2'($urandom_range(0, 2));
            data_size   = 2'($urandom_range(0, 2));
            inst_wstrb  = 4'($urandom);
            data_wstrb  = 4'($urandom);
            inst_addr   = $urandom;
            data_addr   = $urandom;
            inst_wdata  = $urandom;
            data_wdata  = $urandom;
            mem_addr_ok = ($urandom_range(0, 99) < 50);
            mem_data_ok = ($urandom_range(0, 99) < (c < 2900 ? 40 : 90));
            mem_rdata   = $urandom;
            #2;
            model_cycle(c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

Two-to-one arbiter that shares a single SRAM-like memory port between the instruction-fetch requester and the data-access requester of the pipeline (IF stage `inst_sram_*`, EXE/MEM stage `data_sram_*`). It grants one request per accepted address handshake, locks a grant until the downstream port takes it, and tracks outstanding transactions in an in-order ID FIFO so each `data_ok`/`rdata` beat returns to its owner. It sits between the pipeline stages and the SRAM-to-AXI bridge.

## Interface
Parameters:
- `OUTSTANDING`, 4: maximum in-flight accepted transactions; power of two, at least 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `inst_req`, `inst_wr`  in  1 each  instruction-side request and write flag.
- `inst_size`  in  2  0: 1 byte, 1: 2 bytes, 2: 4 bytes.
- `inst_wstrb`  in  4  byte write strobes.
- `inst_addr`, `inst_wdata`  in  32 each  address and write data.
- `inst_addr_ok`, `inst_data_ok`  out  1 each  request accepted; response beat.
- `inst_rdata`  out  32  read data.
- `data_req`, `data_wr`, `data_size`, `data_wstrb`, `data_addr`, `data_wdata`, `data_addr_ok`, `data_data_ok`, `data_rdata`: data-side equivalents, with the same widths and directions as the instruction-side ports.
- `mem_req`, `mem_wr`  out  1 each  downstream request and write flag.
- `mem_size`  out  2  downstream size.
- `mem_wstrb`  out  4  downstream byte write strobes.
- `mem_addr`, `mem_wdata`  out  32 each  downstream address and write data.
- `mem_addr_ok`, `mem_data_ok`  in  1 each  downstream accept; response beat.
- `mem_rdata`  in  32  downstream read data.
- `err_spurious`  out  1  sticky flag: `mem_data_ok` arrived while the ID FIFO was empty.

## Operation
- Grant FSM states:
  - `G_NONE`: no lock held.
  - `G_DATA`: data requester holds the lock.
  - `G_INST`: instruction requester holds the lock.
- In `G_NONE`, arbitration is fixed priority, data over inst.
  - The winner is forwarded to `mem_*` combinationally.
  - If `mem_addr_ok` is not asserted the same cycle, the FSM moves to the winner's lock state.
  - If `mem_addr_ok` is asserted the same cycle, the FSM stays in `G_NONE`.
- In a lock state, only the locked requester is forwarded, even if the other requester raises `req`.
  - On `mem_addr_ok`, the FSM returns to `G_NONE`.
  - If the locked requester drops `req` before `mem_addr_ok`, the lock is released to `G_NONE` and `mem_req` falls that cycle. Aborted requests are legal upstream after an exception flush.
- Requester-side `addr_ok` is `mem_addr_ok & mem_req & (granted id == this requester)`.
- An accepted request (`mem_req & mem_addr_ok`) pushes its owner id (0 = inst, 1 = data) into the ID FIFO. Reads and writes both push, because the downstream returns one `data_ok` for each.
- When the FIFO holds `OUTSTANDING` entries:
  - `mem_req` is forced to 0 and no `addr_ok` is given.
  - This holds even if a pop occurs in the same cycle, giving a deterministic full rule.
- `mem_data_ok` pops the head entry and asserts the owner's `data_ok` for that cycle.
  - `mem_rdata` fans out to both `inst_rdata` and `data_rdata` unmodified.
  - The non-owner's `data_ok` stays 0.
- If `mem_data_ok` arrives with the FIFO empty:
  - No pop and no `data_ok` are issued.
  - `err_spurious` is set and stays set until reset.
- A push and a pop in the same cycle (FIFO not full) leave the count unchanged. Pointers wrap modulo `OUTSTANDING`. The count is `$clog2(OUTSTANDING)+1` bits wide.
- Reset clears:
  - the FSM to `G_NONE`;
  - the FIFO pointers and count to 0;
  - `err_spurious` to 0.
  
  Responses for transactions in flight across reset are treated as spurious afterwards.

## Timing
- While `reset` is high, these outputs are 0: `mem_req`, `inst_addr_ok`, `data_addr_ok`, `inst_data_ok`, `data_data_ok`, `err_spurious`. The remaining `mem_*` fields are don't-care.
- Request path is zero-latency: `*_req` to `mem_req`, and `mem_addr_ok` to `*_addr_ok`, both in the same cycle.
- Response path is zero-latency: `mem_data_ok` to `*_data_ok` in the same cycle.
- FIFO and FSM updates take effect on the edge after the handshake. A `mem_data_ok` in the cycle immediately after acceptance pops that transaction correctly.
- Sustained throughput is 1 accepted request per cycle while the FIFO is not full.

## Structure
- Shared package `sram_arb_pkg`:
  - grant-state encoding `G_NONE=2'd0`, `G_DATA=2'd1`, `G_INST=2'd2`;
  - owner ids `ID_INST=1'b0`, `ID_DATA=1'b1`.
- One sub-module, `id_fifo`: parameterized depth, 1-bit payload, push/pop/full/empty/head outputs, same clock and asynchronous reset.

## Test plan
- Same-cycle requests: `data_req` and `inst_req` high in one cycle, `mem_addr_ok=1` → `mem_addr` equals `data_addr`, `data_addr_ok=1`, `inst_addr_ok=0`. Next cycle `inst` is granted.
- Lock hold: `inst_req` alone, `mem_addr_ok=0` for 3 cycles, then `data_req` rises → `mem_addr` stays `inst_addr` until `mem_addr_ok`. The data request is granted in the following cycle.
- Full FIFO: `OUTSTANDING=4`, four accepts with no `mem_data_ok` → 5th cycle `mem_req=0`. One `mem_data_ok` → `mem_req` returns the next cycle.
- In-order routing: accept inst, data, inst, then 3 `mem_data_ok` beats with rdata `0x11`, `0x22`, `0x33` → `inst_data_ok`/`0x11`, `data_data_ok`/`0x22`, `inst_data_ok`/`0x33`.
- Abort and spurious: locked data request drops `req` → FSM returns to `G_NONE`, FIFO count unchanged. Then `mem_data_ok` with empty FIFO → `err_spurious=1` and no `data_ok`.
- Reset mid-operation: assert `reset` asynchronously with 2 entries outstanding → all outputs 0 immediately. After release, FIFO count is 0 and the FSM is in `G_NONE`.
